// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller that keeps its storage in an external dual-port RAM.
// The RAM has a 1-cycle registered read. A 2-entry output buffer hides that read
// latency, so the FIFO streams one word per cycle when both sides are ready.
//
// Optional feature macro: RAM_FIFO_LEVEL_EN adds the `level` occupancy output.
//
// Ports
//   clk, rst_n       : clock (rising edge), synchronous active-low reset
//   s_valid/s_data   : write-side word offered
//   s_ready          : write-side accept (combinational from state)
//   m_valid/m_data   : read-side word presented (oldest buffered entry)
//   m_ready          : read-side accept
//   ram_wr_*         : RAM write port (combinational from the accept)
//   ram_rd_en/addr   : RAM read request
//   ram_rd_data      : RAM read data, valid the cycle after ram_rd_en
//   level            : ram_count + inflight + out_count (RAM_FIFO_LEVEL_EN only)
module ram_fifo_ctrl #(
   parameter int unsigned ADDR = 9,
   parameter int unsigned DATA = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_valid,
   input  logic [DATA-1:0] s_data,
   output logic            s_ready,
   output logic            m_valid,
   output logic [DATA-1:0] m_data,
   input  logic            m_ready,
   output logic            ram_wr_en,
   output logic [ADDR-1:0] ram_wr_addr,
   output logic [DATA-1:0] ram_wr_data,
   output logic            ram_rd_en,
   output logic [ADDR-1:0] ram_rd_addr,
   input  logic [DATA-1:0] ram_rd_data
`ifdef RAM_FIFO_LEVEL_EN
   ,
   output logic [ADDR+1:0] level
`endif
);

   localparam int unsigned CNT_W = ADDR + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(2 ** ADDR);

   // Pointers and occupancy
   logic [ADDR-1:0]  wr_ptr;
   logic [ADDR-1:0]  rd_ptr;
   logic [CNT_W-1:0] ram_count;
   logic             inflight;
   logic [1:0]       out_count;

   // Output buffer: ob_head is the oldest entry, ob_tail the second one
   logic [DATA-1:0]  ob_head;
   logic [DATA-1:0]  ob_tail;
   logic [DATA-1:0]  ob_head_nxt;
   logic [DATA-1:0]  ob_tail_nxt;
   logic [1:0]       out_count_nxt;

   logic             accept;
   logic             pop;
   logic             rd_issue;
   logic [2:0]       ob_committed;

   // Handshakes
   assign s_ready = rst_n && (ram_count < DEPTH_CNT);
   assign accept  = s_valid && s_ready;
   assign m_valid = rst_n && (out_count != 2'd0);
   assign m_data  = ob_head;
   assign pop     = m_valid && m_ready;

   // RAM write port follows the accept directly
   assign ram_wr_en   = accept;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = s_data;

   // Buffer slots already claimed after this edge; a new read only issues if one is free.
   // ram_count is registered, so a read never targets the word being written this cycle.
   assign ob_committed = 3'(out_count) + 3'(inflight) - 3'(pop);
   assign rd_issue     = rst_n && (ram_count != '0) && (ob_committed < 3'd2);
   assign ram_rd_en    = rd_issue;
   assign ram_rd_addr  = rd_ptr;

`ifdef RAM_FIFO_LEVEL_EN
   localparam int unsigned LVL_W = ADDR + 2;
   assign level = rst_n ? (LVL_W'(ram_count) + LVL_W'(inflight) + LVL_W'(out_count))
                        : '0;
`endif

   // Output buffer next state: the returning read word lands behind any survivor of the pop
   always_comb begin
      ob_head_nxt   = ob_head;
      ob_tail_nxt   = ob_tail;
      out_count_nxt = out_count;
      case ({inflight, pop})
         2'b01: begin
            ob_head_nxt   = ob_tail;
            out_count_nxt = out_count - 2'd1;
         end
         2'b10: begin
            if (out_count == 2'd0) begin
               ob_head_nxt = ram_rd_data;
            end else begin
               ob_tail_nxt = ram_rd_data;
            end
            out_count_nxt = out_count + 2'd1;
         end
         2'b11: begin
            if (out_count == 2'd1) begin
               ob_head_nxt = ram_rd_data;
            end else begin
               ob_head_nxt = ob_tail;
               ob_tail_nxt = ram_rd_data;
            end
         end
         default: begin
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
         inflight  <= 1'b0;
         out_count <= 2'd0;
         ob_head   <= '0;
         ob_tail   <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + ADDR'(1);
         end
         if (rd_issue) begin
            rd_ptr <= rd_ptr + ADDR'(1);
         end
         case ({accept, rd_issue})
            2'b10:   ram_count <= ram_count + CNT_W'(1);
            2'b01:   ram_count <= ram_count - CNT_W'(1);
            default: ram_count <= ram_count;
         endcase
         inflight  <= rd_issue;
         out_count <= out_count_nxt;
         ob_head   <= ob_head_nxt;
         ob_tail   <= ob_tail_nxt;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural 1-cycle-read RAM, scoreboard queue of
// accepted words, directed steps for reset, latency, full, streaming,
// backpressure and mid-stream reset.
module tb_ram_fifo_ctrl;

   localparam int unsigned ADDR  = 9;
   localparam int unsigned DATA  = 10;
   localparam int unsigned DEPTH = 2 ** ADDR;

   logic            clk;
   logic            rst_n;
   logic            s_valid;
   logic [DATA-1:0] s_data;
   logic            s_ready;
   logic            m_valid;
   logic [DATA-1:0] m_data;
   logic            m_ready;
   logic            ram_wr_en;
   logic [ADDR-1:0] ram_wr_addr;
   logic [DATA-1:0] ram_wr_data;
   logic            ram_rd_en;
   logic [ADDR-1:0] ram_rd_addr;
   logic [DATA-1:0] ram_rd_data;
`ifdef RAM_FIFO_LEVEL_EN
   logic [ADDR+1:0] level;
`endif

   ram_fifo_ctrl #(.ADDR(ADDR), .DATA(DATA)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
`ifdef RAM_FIFO_LEVEL_EN
      ,
      .level       (level)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External dual-port RAM with registered read
   logic [DATA-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   int              errors;
   int              checks;
   int              n_acc;
   int              n_pop;
   int              acc_since_rst;
   logic            stalled;
   logic [DATA-1:0] stall_data;
   logic [DATA-1:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock cycle from a falling edge: drive, score, advance to the next falling edge
   task automatic drive_cycle(input logic sv, input logic [DATA-1:0] sd, input logic mr);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      #1;
      if (stalled) begin
         chk("stall_valid", 32'(m_valid), 32'd1);
         chk("stall_data", 32'(m_data), 32'(stall_data));
      end
      if (s_valid && s_ready) begin
         sb.push_back(s_data);
         n_acc++;
         acc_since_rst++;
      end
      if (m_valid && m_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL pop_underflow observed=pop with empty scoreboard expected=no pop");
         end
         if (sb.size() != 0) chk("pop_data", 32'(m_data), 32'(sb.pop_front()));
         n_pop++;
      end
      stalled    = m_valid && !m_ready;
      stall_data = m_data;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_acc;
      int base_pop;
      int gaps;
      errors = 0; checks = 0; n_acc = 0; n_pop = 0; acc_since_rst = 0;
      stalled = 1'b0; stall_data = '0;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // Reset: outputs held low even with s_valid asserted
      @(negedge clk);
      s_valid = 1'b1; s_data = DATA'(10'h0AA);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
      @(posedge clk); @(negedge clk); #1;
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_wr_en2", 32'(ram_wr_en), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
      chk("rst_level", 32'(level), 32'd0);
`endif
      rst_n = 1'b1; s_valid = 1'b0;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      chk("post_rst_m_valid", 32'(m_valid), 32'd0);
      @(posedge clk); @(negedge clk);

      // Empty latency: accept at E0, visible after E2 for exactly one cycle
      s_valid = 1'b1; s_data = DATA'(10'h155); m_ready = 1'b1;
      #1;
      chk("lat_wr_en", 32'(ram_wr_en), 32'd1);
      chk("lat_wr_addr", 32'(ram_wr_addr), 32'd0);
      acc_since_rst++;
      @(posedge clk); @(negedge clk);
      s_valid = 1'b0;
      #1;
      chk("lat_e0_m_valid", 32'(m_valid), 32'd0);
      chk("lat_e0_rd_en", 32'(ram_rd_en), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("lat_e1_m_valid", 32'(m_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("lat_e2_m_valid", 32'(m_valid), 32'd1);
      chk("lat_e2_m_data", 32'(m_data), 32'h155);
      @(posedge clk); @(negedge clk);
      chk("lat_e3_m_valid", 32'(m_valid), 32'd0);
      m_ready = 1'b0;

      // Fill to full with no reads: DEPTH in RAM plus 2 in the output buffer
      base_acc = n_acc;
      for (int i = 0; i < 600; i++) begin
         if (!s_ready) break;
         drive_cycle(1'b1, DATA'(i * 7 + 3), 1'b0);
      end
      chk("fill_accepts", 32'(n_acc - base_acc), 32'(DEPTH + 2));
      s_valid = 1'b1; s_data = DATA'(10'h3FF);
      #1;
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("full_wr_en", 32'(ram_wr_en), 32'd0);
      chk("full_rd_en", 32'(ram_rd_en), 32'd0);
      chk("full_m_valid", 32'(m_valid), 32'd1);
`ifdef RAM_FIFO_LEVEL_EN
      chk("full_level", 32'(level), 32'(DEPTH + 2));
`endif

      // Full with pop and write: pop frees a RAM slot, the next write fills it
      drive_cycle(1'b1, DATA'(10'h3C3), 1'b1);
      chk("full_pop_s_ready", 32'(s_ready), 32'd1);
      base_acc = n_acc;
      drive_cycle(1'b1, DATA'(10'h3C3), 1'b0);
      chk("full_refill_acc", 32'(n_acc - base_acc), 32'd1);
      drive_cycle(1'b0, '0, 1'b0);
      drive_cycle(1'b0, '0, 1'b0);
      chk("refull_s_ready", 32'(s_ready), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
      chk("refull_level", 32'(level), 32'(DEPTH + 2));
`endif

      // Drain everything
      for (int i = 0; i < 1000 && sb.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1);
      chk("drain1_sb", 32'(sb.size()), 32'd0);
      drive_cycle(1'b0, '0, 1'b1);
      chk("drain1_m_valid", 32'(m_valid), 32'd0);

      // Streaming: one word per cycle, output continuous after the 2-edge fill
      base_pop = n_pop;
      gaps = 0;
      for (int i = 0; i < 2010; i++) begin
         if (i >= 3 && i <= 2002 && !m_valid) gaps++;
         drive_cycle(i < 2000, DATA'(i), 1'b1);
      end
      chk("stream_gaps", 32'(gaps), 32'd0);
      chk("stream_pops", 32'(n_pop - base_pop), 32'd2000);
      chk("stream_wr_ptr", 32'(ram_wr_addr), 32'(acc_since_rst % DEPTH));
      chk("stream_rd_ptr", 32'(ram_rd_addr), 32'(acc_since_rst % DEPTH));

      // Backpressure: random s_valid, ~30% m_ready
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), DATA'($urandom),
                     1'($urandom_range(0, 99) < 30));
      end
      for (int i = 0; i < 2000 && sb.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1);
      chk("bp_drain_sb", 32'(sb.size()), 32'd0);
      drive_cycle(1'b0, '0, 1'b1);
      chk("bp_m_valid", 32'(m_valid), 32'd0);

      // Reset mid-stream with 100 words queued
      for (int i = 0; i < 100; i++) drive_cycle(1'b1, DATA'(i + 256), 1'b0);
      s_valid = 1'b1; s_data = DATA'(10'h111); m_ready = 1'b0; rst_n = 1'b0;
      #1;
      chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
      chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("mid_rst_rd_en", 32'(ram_rd_en), 32'd0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1; s_valid = 1'b0;
      sb.delete();
      stalled = 1'b0;
      acc_since_rst = 0;
      #1;
      chk("mid_post_m_valid", 32'(m_valid), 32'd0);
      chk("mid_post_m_data", 32'(m_data), 32'd0);
      chk("mid_post_wr_ptr", 32'(ram_wr_addr), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
      chk("mid_post_level", 32'(level), 32'd0);
`endif
      base_pop = n_pop;
      drive_cycle(1'b1, DATA'(10'h2AA), 1'b1);
      drive_cycle(1'b1, DATA'(10'h0F0), 1'b1);
      drive_cycle(1'b0, '0, 1'b1);
      chk("mid_first_out", 32'(m_data), 32'h2AA);
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);
      chk("mid_pops", 32'(n_pop - base_pop), 32'd2);
      chk("mid_sb", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 9, RAM address width; RAM depth DEPTH = 2**ADDR.
REQ-002 SHALL have parameter DATA, default 10, word width.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_valid  in  1  write-side word valid.
REQ-006 SHALL have port s_data  in  DATA  write-side word.
REQ-007 SHALL have port s_ready  out  1  write-side accept.
REQ-008 SHALL have port m_valid  out  1  read-side word valid.
REQ-009 SHALL have port m_data  out  DATA  read-side word.
REQ-010 SHALL have port m_ready  in  1  read-side accept.
REQ-011 SHALL have ports ram_wr_en out 1, ram_wr_addr out ADDR, ram_wr_data out DATA: write port to an external dual-port RAM.
REQ-012 SHALL have ports ram_rd_en out 1, ram_rd_addr out ADDR, ram_rd_data in DATA: read port to that RAM, which has 1-cycle registered read.
REQ-013 SHALL have port level  out  ADDR+2  total occupancy (only with RAM_FIFO_LEVEL_EN).

Function
REQ-014 SHALL accept a word on an edge where s_valid && s_ready; s_ready = rst_n && (ram_count < DEPTH).
REQ-015 SHALL drive ram_wr_en = s_valid && s_ready, ram_wr_addr = wr_ptr, ram_wr_data = s_data, combinationally; wr_ptr increments modulo DEPTH per accept.
REQ-016 SHALL track ram_count (0..DEPTH) = words written but not yet read-issued; +1 on accept, -1 on read issue, unchanged when both occur.
REQ-017 SHALL hold a 2-entry output buffer (out_count 0..2) plus an inflight flag for the read in the RAM's output register.
REQ-018 SHALL issue a read (ram_rd_en=1, ram_rd_addr=rd_ptr, rd_ptr+1 modulo DEPTH) when rst_n && ram_count != 0 && (out_count + inflight - pop) < 2, where pop = m_valid && m_ready.
REQ-019 SHALL set inflight on the issue edge; on the next edge SHALL write ram_rd_data into the output buffer, in order.
REQ-020 SHALL drive m_valid = (out_count != 0) and m_data = oldest buffer entry; m_data stable while m_valid && !m_ready.
REQ-021 SHALL give 2-edge latency on an empty FIFO: word accepted at edge E0 -> m_valid high after edge E2.
REQ-022 SHALL sustain 1 word/cycle throughput when s_valid and m_ready are held high.
REQ-023 SHALL never read an address in the cycle it is written, since a read issues only on ram_count counted at a prior edge.
REQ-024 SHALL treat full as ram_count == DEPTH (s_ready=0) and empty as ram_count == 0 && !inflight && out_count == 0 (m_valid=0).
REQ-025 SHALL handle simultaneous accept and pop at any occupancy, including full-with-pop and empty-to-one, without loss or duplication.
REQ-026 SHALL wrap both pointers from DEPTH-1 to 0 with no gap.
REQ-027 SHALL compute level = ram_count + inflight + out_count, maximum DEPTH+2.

Reset
REQ-028 SHALL, while rst_n=0 at an edge, clear wr_ptr, rd_ptr, ram_count, inflight, and out_count to 0.
REQ-029 SHALL hold s_ready=0, m_valid=0, ram_wr_en=0, ram_rd_en=0, and level=0 during reset; m_data SHALL read 0 after reset.
REQ-030 SHALL discard all queued and in-flight words on reset mid-operation; RAM contents are not cleared and are never re-read.

Configuration
REQ-031 SHALL, with RAM_FIFO_LEVEL_EN defined, include the level port and its logic per REQ-027.
REQ-032 SHALL, without RAM_FIFO_LEVEL_EN, omit the level port; all other behaviour is identical.

Verification
REQ-033 SHALL cover empty latency: write 0x155 at E0, m_ready=1 -> m_valid=1 and m_data=0x155 after E2, one cycle only.
REQ-034 SHALL cover fill to full (ADDR=9): 512 writes with m_ready=0 -> s_ready=0 after the 512th accept plus 2 buffered reads; level=514; s_valid=1 then causes no ram_wr_en.
REQ-035 SHALL cover streaming: 2000 words of incrementing data, s_valid=m_ready=1 -> outputs in order with no gaps after the first 2 cycles, and pointers wrap 3 times.
REQ-036 SHALL cover backpressure: random m_ready with 30% duty, random s_valid -> scoreboard exact order, and m_data stable while stalled.
REQ-037 SHALL cover reset mid-stream: rst_n=0 for 1 edge with 100 words queued -> m_valid=0, level=0, and the next written word is the first out.
REQ-038 SHALL cover full with simultaneous accept and pop: at ram_count=512 pop one and write -> no loss, and level is unchanged after settle.
